// File: rtl/multicycle_control.sv
// Multi-cycle main controller for the RV32 education core.
// Sequences the shared-memory datapath through FETCH/DECODE/EXEC/MEM/WB,
// runs a memory-wait watchdog and halts on illegal opcodes or stalled memory.
// Optional feature: define MC_JALR_EN to accept JALR (opcode 1100111, funct3 000).
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | request instruction at PC, latch IR and PC+4 on mem_ready
// DECODE | compute branch/jump target into ALUOut, check opcode legality
// EXEC   | ALU operation, branch/jump resolution, address generation
// MEM    | data access at ALUOut (load or store)
// WB     | register file write from ALUOut or MDR
// HALT   | fault stop, left only through reset
module multicycle_control #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [2:0] imm_sel,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_JAL   = 3'b011;
  localparam logic [2:0] ALU_OPIMM = 3'b100;

  localparam bit                   WD_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] WD_TERM = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t               cur, nxt;
  logic [TIMEOUT_W-1:0] wd_cnt, wd_cnt_nxt;
  logic                 req_c, we_c, irw_c, pcw_c, rgw_c;
  logic                 set_ill, set_to;
  logic                 wd_expired, waiting;

  logic is_r, is_opimm, is_lw, is_sw, is_branch, is_beq, is_bne, is_jal, is_jalr;
  logic legal;

  assign is_r      = (opcode == OP_R);
  assign is_opimm  = (opcode == OP_IMM);
  assign is_lw     = (opcode == OP_LOAD);
  assign is_sw     = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_beq    = is_branch && (funct3 == 3'b000);
  assign is_bne    = is_branch && (funct3 == 3'b001);
  assign is_jal    = (opcode == OP_JAL);
`ifdef MC_JALR_EN
  localparam logic [6:0] OP_JALR = 7'b1100111;
  assign is_jalr   = (opcode == OP_JALR) && (funct3 == 3'b000);
`else
  assign is_jalr   = 1'b0;
`endif
  assign legal = is_r | is_opimm | is_lw | is_sw | is_beq | is_bne | is_jal | is_jalr;

  // Watchdog only runs while the controller is waiting on memory.
  assign waiting    = (cur == S_FETCH) || (cur == S_MEM);
  assign wd_expired = WD_EN && waiting && (wd_cnt == WD_TERM);

  // Next-state and datapath control decode.
  always_comb begin
    nxt          = cur;
    req_c        = 1'b0;
    we_c         = 1'b0;
    irw_c        = 1'b0;
    pcw_c        = 1'b0;
    rgw_c        = 1'b0;
    mem_addr_sel = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = ALU_ADD;
    imm_sel      = IMM_NONE;
    wb_sel       = 2'b00;
    set_ill      = 1'b0;
    set_to       = 1'b0;
    case (cur)
      S_FETCH: begin
        req_c     = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          irw_c = 1'b1;
          pcw_c = 1'b1;
          nxt   = S_DECODE;
        end else if (wd_expired) begin
          nxt    = S_HALT;
          set_to = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        if (is_branch)   imm_sel = IMM_B;
        else if (is_jal) imm_sel = IMM_J;
        if (legal) begin
          nxt = S_EXEC;
        end else begin
          nxt     = S_HALT;
          set_ill = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          alu_src_a = 2'b01;
          alu_op    = ALU_RTYPE;
          nxt       = S_WB;
        end else if (is_opimm) begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          imm_sel   = IMM_I;
          alu_op    = ALU_OPIMM;
          nxt       = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          imm_sel   = is_sw ? IMM_S : IMM_I;
          nxt       = S_MEM;
        end else if (is_beq || is_bne) begin
          alu_src_a = 2'b01;
          alu_op    = ALU_SUB;
          pc_src    = 1'b1;
          pcw_c     = is_beq ? alu_zero : !alu_zero;
          nxt       = S_FETCH;
        end else if (is_jal) begin
          pcw_c  = 1'b1;
          pc_src = 1'b1;
          rgw_c  = 1'b1;
          wb_sel = 2'b10;
          alu_op = ALU_JAL;
          nxt    = S_FETCH;
        end else if (is_jalr) begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          imm_sel   = IMM_I;
          pcw_c     = 1'b1;
          rgw_c     = 1'b1;
          wb_sel    = 2'b10;
          nxt       = S_FETCH;
        end else begin
          // IR changed under us; treat as an illegal instruction.
          nxt     = S_HALT;
          set_ill = 1'b1;
        end
      end
      S_MEM: begin
        req_c        = 1'b1;
        mem_addr_sel = 1'b1;
        we_c         = is_sw;
        if (mem_ready) begin
          nxt = is_lw ? S_WB : S_FETCH;
        end else if (wd_expired) begin
          nxt    = S_HALT;
          set_to = 1'b1;
        end
      end
      S_WB: begin
        rgw_c  = 1'b1;
        wb_sel = is_lw ? 2'b01 : 2'b00;
        nxt    = S_FETCH;
      end
      S_HALT: begin
        nxt = S_HALT;
      end
      default: begin
        nxt = S_FETCH;
      end
    endcase
  end

  // Watchdog counter: cleared on state change or a completed access, saturating.
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if ((nxt != cur) || mem_ready) wd_cnt_nxt = '0;
    else if (waiting && (wd_cnt != WD_MAX)) wd_cnt_nxt = wd_cnt + 1'b1;
  end

  // State register, watchdog count and sticky fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_FETCH;
      wd_cnt  <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cur    <= nxt;
      wd_cnt <= wd_cnt_nxt;
      if (set_ill) illegal <= 1'b1;
      if (set_to)  timeout <= 1'b1;
    end
  end

  // Strobes are gated by reset so nothing fires once rst_n falls.
  assign mem_req   = req_c & rst_n;
  assign mem_we    = we_c  & rst_n;
  assign ir_write  = irw_c & rst_n;
  assign pc_write  = pcw_c & rst_n;
  assign reg_write = rgw_c & rst_n;
  assign state     = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (built with TIMEOUT = 4).
module tb_multicycle_control;

  localparam int TB_TO = 4;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;

  localparam logic [6:0] OP_R = 7'h33, OP_IMM = 7'h13, OP_LW = 7'h03, OP_SW = 7'h23;
  localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_BAD = 7'h7F;

  typedef struct packed {
    logic [2:0] st;
    logic req, we, asel, irw, pcw, rgw, psrc;
    logic [1:0] sa, sb;
    logic [2:0] aop, imm;
    logic [1:0] wb;
    logic ill, to;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero, mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, pc_src;
  logic [1:0] alu_src_a, alu_src_b, wb_sel;
  logic [2:0] alu_op, imm_sel, state;
  logic       illegal, timeout;

  int   checks = 0;
  int   failures = 0;
  bit   m_ill = 0, m_to = 0;
  bit   exp_valid = 0;
  obs_t exp_o, dut_o;
  obs_t trace[$];
  int   cyc;

  multicycle_control #(.TIMEOUT_W(8), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_sel(imm_sel), .wb_sel(wb_sel), .illegal(illegal),
    .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  assign dut_o = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write,
                  pc_src, alu_src_a, alu_src_b, alu_op, imm_sel, wb_sel, illegal, timeout};

  // What the controller must present in a given phase, straight from the control table.
  function automatic obs_t expect_out(int ph, logic [6:0] op, logic [2:0] f3,
                                      logic z, logic rdy, logic in_rst);
    obs_t o;
    o     = '0;
    o.st  = 3'(ph);
    o.ill = m_ill;
    o.to  = m_to;
    case (ph)
      P_FETCH: begin
        o.req = 1; o.sb = 2'b01;
        if (rdy) begin o.irw = 1; o.pcw = 1; end
      end
      P_DECODE: begin
        o.sa = 2'b10; o.sb = 2'b10;
        o.imm = (op == OP_BR) ? 3'd3 : (op == OP_JAL) ? 3'd4 : 3'd0;
      end
      P_EXEC: begin
        if (op == OP_R) begin o.sa = 2'b01; o.aop = 3'b010; end
        else if (op == OP_IMM) begin o.sa = 2'b01; o.sb = 2'b10; o.imm = 3'd1; o.aop = 3'b100; end
        else if (op == OP_LW) begin o.sa = 2'b01; o.sb = 2'b10; o.imm = 3'd1; end
        else if (op == OP_SW) begin o.sa = 2'b01; o.sb = 2'b10; o.imm = 3'd2; end
        else if (op == OP_BR) begin
          o.sa = 2'b01; o.aop = 3'b001; o.psrc = 1;
          o.pcw = (f3 == 3'b000) ? z : !z;
        end
        else if (op == OP_JAL) begin o.pcw = 1; o.psrc = 1; o.rgw = 1; o.wb = 2'b10; o.aop = 3'b011; end
        else if (op == OP_JALR) begin
          o.sa = 2'b01; o.sb = 2'b10; o.imm = 3'd1; o.pcw = 1; o.rgw = 1; o.wb = 2'b10;
        end
      end
      P_MEM: begin o.req = 1; o.asel = 1; o.we = (op == OP_SW); end
      P_WB: begin o.rgw = 1; o.wb = (op == OP_LW) ? 2'b01 : 2'b00; end
      default: ;
    endcase
    if (in_rst) begin o.req = 0; o.we = 0; o.irw = 0; o.pcw = 0; o.rgw = 0; end
    return o;
  endfunction

  function automatic bit is_legal(logic [6:0] op, logic [2:0] f3);
    bit jalr_ok;
`ifdef MC_JALR_EN
    jalr_ok = (op == OP_JALR) && (f3 == 3'b000);
`else
    jalr_ok = 1'b0;
`endif
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_JAL) || ((op == OP_BR) && (f3 <= 3'b001)) || jalr_ok;
  endfunction

  // Single compare process: every cycle with a valid expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      trace.push_back(dut_o);
      if (dut_o !== exp_o) begin
        failures++;
        $display("FAIL cycle_check t=%0t actual=%h required=%h", $time, dut_o, exp_o);
      end
    end
  end

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Called at posedge+1 after inputs are driven; expectation holds until the next posedge.
  task automatic step(input int ph);
    exp_o     = expect_out(ph, opcode, funct3, alu_zero, mem_ready, !rst_n);
    exp_valid = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_ill = 0;
    m_to  = 0;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'($urandom);
      opcode    = 7'($urandom);
      step(P_FETCH);
    end
    rst_n = 1;
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      opcode    = 7'($urandom);
      mem_ready = 1'($urandom);
      step(P_HALT);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int fwait, input int mwait, output int cycles);
    cycles = 0;
    trace.delete();
    for (int i = 0; i <= fwait; i++) begin
      opcode    = 7'($urandom);
      funct3    = 3'($urandom);
      alu_zero  = 1'($urandom);
      mem_ready = (i == fwait);
      step(P_FETCH);
      cycles++;
      if (i == TB_TO && i < fwait) begin
        m_to = 1;
        step(P_HALT);
        return;
      end
    end
    opcode    = op;
    funct3    = f3;
    alu_zero  = z;
    mem_ready = 1'($urandom);
    step(P_DECODE);
    cycles++;
    if (!is_legal(op, f3)) begin
      m_ill = 1;
      step(P_HALT);
      return;
    end
    mem_ready = 1'($urandom);
    step(P_EXEC);
    cycles++;
    if (op == OP_BR || op == OP_JAL || op == OP_JALR) return;
    if (op == OP_LW || op == OP_SW) begin
      for (int j = 0; j <= mwait; j++) begin
        mem_ready = (j == mwait);
        step(P_MEM);
        cycles++;
        if (j == TB_TO && j < mwait) begin
          m_to = 1;
          step(P_HALT);
          return;
        end
      end
      if (op == OP_SW) return;
    end
    mem_ready = 1'($urandom);
    step(P_WB);
    cycles++;
  endtask

  initial begin
    rst_n = 0; opcode = '0; funct3 = '0; alu_zero = 0; mem_ready = 0;
    @(posedge clk);
    #1;
    do_reset();

    // ADD, zero-wait memory
    run_instr(OP_R, 3'b000, 0, 0, 0, cyc);
    chk("add_cycles", cyc, 4);
    chk("add_trace_len", trace.size(), 4);
    chk("add_states", {trace[0].st, trace[1].st, trace[2].st, trace[3].st}, 12'h054);
    chk("add_irw_pcw_c0", {trace[0].irw, trace[0].pcw}, 3);
    chk("add_wb_c3", {trace[3].rgw, trace[3].wb}, 3'b100);

    run_instr(OP_IMM, 3'b000, 0, 2, 0, cyc);
    chk("opimm_cycles", cyc, 6);

    // LW with three memory wait cycles
    run_instr(OP_LW, 3'b010, 0, 0, 3, cyc);
    chk("lw_cycles", cyc, 8);
    chk("lw_asel_mem", {trace[3].asel, trace[4].asel, trace[5].asel, trace[6].asel}, 4'hF);
    chk("lw_mem_states", {trace[3].st, trace[6].st}, 6'o33);
    chk("lw_wb_sel", {trace[7].st, trace[7].wb}, 5'b10001);

    run_instr(OP_SW, 3'b010, 0, 0, 1, cyc);
    chk("sw_cycles", cyc, 5);

    // Branches with alu_zero = 1
    run_instr(OP_BR, 3'b001, 1, 0, 0, cyc);
    chk("bne_cycles", cyc, 3);
    chk("bne_pcw", trace[2].pcw, 0);
    chk("bne_dec_imm", trace[1].imm, 3);
    run_instr(OP_BR, 3'b000, 1, 0, 0, cyc);
    chk("beq_cycles", cyc, 3);
    chk("beq_pcw_psrc", {trace[2].pcw, trace[2].psrc}, 3);
    run_instr(OP_BR, 3'b000, 0, 0, 0, cyc);
    run_instr(OP_BR, 3'b001, 0, 1, 0, cyc);

    run_instr(OP_JAL, 3'b000, 0, 0, 0, cyc);
    chk("jal_cycles", cyc, 3);
    chk("jal_wb_sel", trace[2].wb, 2);

    // JALR: legal only with MC_JALR_EN
    run_instr(OP_JALR, 3'b000, 0, 0, 0, cyc);
    if (m_ill) begin
      hold_halt(2);
      do_reset();
    end

    // Branch with unsupported funct3
    run_instr(OP_BR, 3'b100, 0, 0, 0, cyc);
    chk("br_f3_illegal", illegal, 1);
    do_reset();

    // Illegal opcode, sticky for 20 cycles, cleared by reset
    run_instr(OP_BAD, 3'b000, 0, 0, 0, cyc);
    hold_halt(20);
    chk("bad_op_illegal", illegal, 1);
    chk("bad_op_state", state, 5);
    do_reset();
    chk("post_reset_illegal", illegal, 0);

    // Watchdog fires in FETCH
    run_instr(OP_R, 3'b000, 0, 10, 0, cyc);
    chk("wd_fetch_cycles", cyc, 5);
    chk("wd_timeout", {state, timeout}, 4'b1011);
    hold_halt(3);
    do_reset();

    // mem_ready on the terminal count completes normally
    run_instr(OP_R, 3'b000, 0, TB_TO, 0, cyc);
    chk("wd_edge_cycles", cyc, 8);
    chk("wd_edge_timeout", timeout, 0);

    // Reset during MEM of SW
    trace.delete();
    opcode = 7'($urandom); mem_ready = 1; step(P_FETCH);
    opcode = OP_SW; funct3 = 3'b010; mem_ready = 0; step(P_DECODE);
    step(P_EXEC);
    step(P_MEM);
    rst_n = 0;
    m_ill = 0;
    m_to  = 0;
    #1;
    chk("abort_req_we", {mem_req, mem_we}, 0);
    chk("abort_state", state, 0);
    step(P_FETCH);
    step(P_FETCH);
    rst_n = 1;
    mem_ready = 0;
    step(P_FETCH);

    exp_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
